// File: rtl/eeg_xram_rd_arb.sv
// Burst-locked round-robin / fixed-priority read arbiter for one XRAM lane.
// Tags each accepted beat with its owner and steers returned data and back-pressure.
module eeg_xram_rd_arb #(
  parameter int unsigned REQ_NUM = 4,
  parameter int unsigned REQ_IW  = 2,
  parameter int unsigned ADD_AW  = 12,
  parameter int unsigned DAT_DW  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      CFG_ENA,
  input  logic                      CFG_FIX,
  input  logic [REQ_NUM-1:0]        REQ_ADD_VLD,
  input  logic [REQ_NUM-1:0]        REQ_ADD_LST,
  output logic [REQ_NUM-1:0]        REQ_ADD_RDY,
  input  logic [REQ_NUM*ADD_AW-1:0] REQ_ADD_ADD,
  output logic [REQ_NUM-1:0]        REQ_DAT_VLD,
  output logic [REQ_NUM-1:0]        REQ_DAT_LST,
  input  logic [REQ_NUM-1:0]        REQ_DAT_RDY,
  output logic [DAT_DW-1:0]         REQ_DAT_DAT,
  output logic                      XRAM_ADD_VLD,
  output logic                      XRAM_ADD_LST,
  output logic [ADD_AW-1:0]         XRAM_ADD_ADD,
  input  logic                      XRAM_ADD_RDY,
  input  logic                      XRAM_DAT_VLD,
  input  logic                      XRAM_DAT_LST,
  input  logic [DAT_DW-1:0]         XRAM_DAT_DAT,
  output logic                      XRAM_DAT_RDY,
  output logic                      ARB_BUSY,
  output logic [REQ_IW-1:0]         ARB_OWN
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [REQ_IW-1:0]   own_q, own_d;
  logic [REQ_IW-1:0]   ptr_q, ptr_d;
  logic [REQ_IW-1:0]   rsp_own_q;
  logic [REQ_IW-1:0]   win_idx;
  logic [REQ_IW-1:0]   rr_idx;
  logic                win_vld;
  logic                lst_acc;
  logic [ADD_AW-1:0]   add_arr [REQ_NUM];

  // Index addition modulo REQ_NUM; both operands are always below REQ_NUM.
  function automatic logic [REQ_IW-1:0] wrap_add(input logic [REQ_IW-1:0] a,
                                                 input int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= REQ_NUM) s = s - REQ_NUM;
    return REQ_IW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(REQ_NUM); i++) add_arr[i] = REQ_ADD_ADD[i*ADD_AW +: ADD_AW];
  end

  // Winner search; descending loops so the highest-priority candidate is written last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_idx  = '0;
    if (CFG_FIX) begin
      for (int i = int'(REQ_NUM) - 1; i >= 0; i--) begin
        if (REQ_ADD_VLD[i]) begin
          win_vld = 1'b1;
          win_idx = REQ_IW'(i);
        end
      end
    end else begin
      for (int k = int'(REQ_NUM) - 1; k >= 0; k--) begin
        rr_idx = wrap_add(ptr_q, 32'(k));
        if (REQ_ADD_VLD[rr_idx]) begin
          win_vld = 1'b1;
          win_idx = rr_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      own_q     <= '0;
      ptr_q     <= '0;
      rsp_own_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      // Same enable as the lane's data registers, so the tag tracks the presented beat.
      if (XRAM_ADD_RDY) rsp_own_q <= own_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    ptr_d        = ptr_q;
    lst_acc      = 1'b0;
    XRAM_ADD_VLD = 1'b0;
    XRAM_ADD_LST = 1'b0;
    XRAM_ADD_ADD = add_arr[0];
    REQ_ADD_RDY  = '0;
    case (state_q)
      IDLE: begin
        if (CFG_ENA && win_vld) begin
          state_d = GRANT;
          own_d   = win_idx;
        end
      end
      GRANT: begin
        XRAM_ADD_VLD       = REQ_ADD_VLD[own_q];
        XRAM_ADD_LST       = REQ_ADD_LST[own_q];
        XRAM_ADD_ADD       = add_arr[own_q];
        REQ_ADD_RDY[own_q] = XRAM_ADD_RDY;
        lst_acc = REQ_ADD_VLD[own_q] & REQ_ADD_LST[own_q] & XRAM_ADD_RDY;
        if (lst_acc) begin
          state_d = IDLE;
          ptr_d   = wrap_add(own_q, 32'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    REQ_DAT_VLD            = '0;
    REQ_DAT_LST            = '0;
    REQ_DAT_VLD[rsp_own_q] = XRAM_DAT_VLD;
    REQ_DAT_LST[rsp_own_q] = XRAM_DAT_LST;
  end

  assign XRAM_DAT_RDY = REQ_DAT_RDY[rsp_own_q];
  assign REQ_DAT_DAT  = XRAM_DAT_DAT;
  assign ARB_BUSY     = (state_q == GRANT);
  assign ARB_OWN      = own_q;

endmodule

// File: tb/tb_eeg_xram_rd_arb.sv
// Bench for eeg_xram_rd_arb: directed bursts, one-cycle-latency lane model, scoreboard on returned beats.
module tb_eeg_xram_rd_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int WAIT_MAX = 300;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst, cfg_ena, cfg_fix;
  logic [N-1:0]    req_add_vld, req_add_lst, req_add_rdy;
  logic [N*AW-1:0] req_add_add;
  logic [N-1:0]    req_dat_vld, req_dat_lst, req_dat_rdy;
  logic [DW-1:0]   req_dat_dat;
  logic            xram_add_vld, xram_add_lst, xram_add_rdy;
  logic [AW-1:0]   xram_add_add;
  logic            xram_dat_vld, xram_dat_lst, xram_dat_rdy;
  logic [DW-1:0]   xram_dat_dat;
  logic            arb_busy;
  logic [IW-1:0]   arb_own;

  logic          vld_a [N];
  logic          lst_a [N];
  logic [AW-1:0] add_a [N];

  exp_t sb [$];
  exp_t mon_e;
  int   checks;
  int   failures;

  int t1_busy [5]  = '{0, 1, 1, 1, 0};
  int t1_vld  [5]  = '{0, 0, 2, 2, 2};
  int t2_busy [14] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
  int t2_vld  [14] = '{0, 0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0};
  int t2_own  [14] = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, -1};
  int t3_own  [6]  = '{-1, 2, 2, 2, -1, 0};

  eeg_xram_rd_arb #(.REQ_NUM(N), .REQ_IW(IW), .ADD_AW(AW), .DAT_DW(DW)) dut (
    .clk(clk), .rst(rst), .CFG_ENA(cfg_ena), .CFG_FIX(cfg_fix),
    .REQ_ADD_VLD(req_add_vld), .REQ_ADD_LST(req_add_lst), .REQ_ADD_RDY(req_add_rdy),
    .REQ_ADD_ADD(req_add_add), .REQ_DAT_VLD(req_dat_vld), .REQ_DAT_LST(req_dat_lst),
    .REQ_DAT_RDY(req_dat_rdy), .REQ_DAT_DAT(req_dat_dat),
    .XRAM_ADD_VLD(xram_add_vld), .XRAM_ADD_LST(xram_add_lst), .XRAM_ADD_ADD(xram_add_add),
    .XRAM_ADD_RDY(xram_add_rdy), .XRAM_DAT_VLD(xram_dat_vld), .XRAM_DAT_LST(xram_dat_lst),
    .XRAM_DAT_DAT(xram_dat_dat), .XRAM_DAT_RDY(xram_dat_rdy),
    .ARB_BUSY(arb_busy), .ARB_OWN(arb_own)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      req_add_vld[i]               = vld_a[i];
      req_add_lst[i]               = lst_a[i];
      req_add_add[i*AW +: AW]      = add_a[i];
    end
  end

  // Data the lane returns for an address.
  function automatic logic [7:0] lane_dat(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  // RAM lane: one-cycle read latency, address ready tied to data ready.
  assign xram_add_rdy = xram_dat_rdy;
  always @(posedge clk) begin
    if (rst) begin
      xram_dat_vld <= 1'b0;
      xram_dat_lst <= 1'b0;
      xram_dat_dat <= '0;
    end else if (xram_add_rdy) begin
      xram_dat_vld <= xram_add_vld;
      xram_dat_lst <= xram_add_lst;
      xram_dat_dat <= lane_dat(xram_add_add);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int r, input logic [AW-1:0] base, input int n);
    exp_t e;
    for (int b = 0; b < n; b++) begin
      e.r = 8'(r);
      e.d = lane_dat(base + AW'(b));
      e.l = (b == n - 1);
      sb.push_back(e);
    end
  endtask

  // Drives one burst on requester r; call at posedge+1.
  task automatic burst(input int r, input logic [AW-1:0] base, input int n);
    int w;
    for (int b = 0; b < n; b++) begin
      vld_a[r] = 1'b1;
      lst_a[r] = (b == n - 1);
      add_a[r] = base + AW'(b);
      w = 0;
      @(negedge clk);
      while (!req_add_rdy[r] && w < WAIT_MAX) begin
        @(negedge clk);
        w++;
      end
      chk("add_accept_in_time", 32'(w < WAIT_MAX), 32'd1);
      @(posedge clk); #1;
    end
    vld_a[r] = 1'b0;
    lst_a[r] = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every returned-data handshake is compared against the next expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req_dat_vld[i] && req_dat_rdy[i]) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat_req", 32'(i), 32'hFF);
          end else begin
            mon_e = sb.pop_front();
            chk("beat_req_dat_lst", {8'(i), req_dat_dat, 15'd0, req_dat_lst[i]},
                {mon_e.r, mon_e.d, 15'd0, mon_e.l});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < int'(N); i++) begin
      vld_a[i] = 1'b0;
      lst_a[i] = 1'b0;
      add_a[i] = '0;
    end
    add_a[0]    = 12'h0AB;
    rst         = 1'b1;
    cfg_ena     = 1'b1;
    cfg_fix     = 1'b0;
    req_dat_rdy = 4'b1110;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_own", 32'(arb_own), 32'd0);
    chk("rst_add_rdy", 32'(req_add_rdy), 32'd0);
    chk("rst_xram_vld", 32'(xram_add_vld), 32'd0);
    chk("rst_xram_lst", 32'(xram_add_lst), 32'd0);
    chk("rst_xram_add", 32'(xram_add_add), 32'h0AB);
    chk("rst_dat_rdy_from_req0", 32'(xram_dat_rdy), 32'd0);
    chk("rst_dat_vld", 32'(req_dat_vld), 32'd0);
    @(posedge clk); #1;
    rst         = 1'b0;
    add_a[0]    = '0;
    req_dat_rdy = 4'b1111;

    // single burst on req1
    push_burst(1, 12'h010, 3);
    fork
      burst(1, 12'h010, 3);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("t1_busy", 32'(arb_busy), 32'(t1_busy[k]));
          chk("t1_dat_vld", 32'(req_dat_vld), 32'(t1_vld[k]));
          if (k == 1) begin
            chk("t1_own", 32'(arb_own), 32'd1);
            chk("t1_add_rdy", 32'(req_add_rdy), 32'h2);
            chk("t1_xram_add", 32'(xram_add_add), 32'h010);
          end
        end
      end
    join
    drain();
    chk("t1_ptr", 32'(dut.ptr_q), 32'd2);

    // round-robin from ptr 0, four simultaneous 2-beat bursts
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 4; r++) push_burst(r, AW'(r * 256 + 32), 2);
    fork
      burst(0, 12'h020, 2);
      burst(1, 12'h120, 2);
      burst(2, 12'h220, 2);
      burst(3, 12'h320, 2);
      begin
        for (int k = 0; k < 14; k++) begin
          @(negedge clk);
          chk("t2_busy", 32'(arb_busy), 32'(t2_busy[k]));
          chk("t2_dat_vld", 32'(req_dat_vld), 32'(t2_vld[k]));
          if (t2_own[k] >= 0) chk("t2_own", 32'(arb_own), 32'(t2_own[k]));
        end
      end
    join
    drain();

    // fixed priority: req0 joins during req2's burst
    @(posedge clk); #1;
    cfg_fix = 1'b1;
    push_burst(2, 12'h240, 3);
    push_burst(0, 12'h040, 2);
    push_burst(3, 12'h340, 2);
    fork
      burst(2, 12'h240, 3);
      burst(3, 12'h340, 2);
      begin
        repeat (2) begin @(posedge clk); #1; end
        burst(0, 12'h040, 2);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (t3_own[k] >= 0) chk("t3_own", 32'(arb_own), 32'(t3_own[k]));
        end
      end
    join
    drain();
    cfg_fix = 1'b0;

    // back-pressure on req1's second returned beat
    @(posedge clk); #1;
    push_burst(1, 12'h150, 4);
    fork
      burst(1, 12'h150, 4);
      begin
        repeat (3) begin @(posedge clk); #1; end
        req_dat_rdy[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("t4_add_rdy_stall", 32'(req_add_rdy), 32'd0);
          chk("t4_xram_dat_rdy", 32'(xram_dat_rdy), 32'd0);
          chk("t4_dat_vld_hold", 32'(req_dat_vld), 32'h2);
          chk("t4_dat_hold", 32'(req_dat_dat), 32'(lane_dat(12'h151)));
          @(posedge clk); #1;
        end
        req_dat_rdy[1] = 1'b1;
      end
    join
    drain();

    // CFG_ENA gating: req0 finishes, req1 waits until re-enabled
    @(posedge clk); #1;
    push_burst(0, 12'h060, 4);
    push_burst(1, 12'h160, 2);
    fork
      burst(0, 12'h060, 4);
      burst(1, 12'h160, 2);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_ena = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("t5_gated_busy", 32'(arb_busy), 32'd0);
          chk("t5_gated_add_rdy", 32'(req_add_rdy), 32'd0);
          @(posedge clk); #1;
        end
        cfg_ena = 1'b1;
        @(negedge clk);
        chk("t5_enable_cycle_busy", 32'(arb_busy), 32'd0);
        @(negedge clk);
        chk("t5_grant_busy", 32'(arb_busy), 32'd1);
        chk("t5_grant_own", 32'(arb_own), 32'd1);
      end
    join
    drain();

    // reset during the second beat of a req3 burst
    @(posedge clk); #1;
    vld_a[3] = 1'b1;
    lst_a[3] = 1'b0;
    add_a[3] = 12'h370;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_busy_before", 32'(arb_busy), 32'd1);
    chk("t6_own_before", 32'(arb_own), 32'd3);
    @(posedge clk); #1;
    add_a[3] = 12'h371;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    vld_a[3] = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_rst", 32'(arb_busy), 32'd0);
    chk("t6_ptr_after_rst", 32'(dut.ptr_q), 32'd0);
    chk("t6_own_after_rst", 32'(arb_own), 32'd0);
    chk("t6_dat_vld_after_rst", 32'(req_dat_vld), 32'd0);
    @(posedge clk); #1;
    push_burst(3, 12'h380, 2);
    burst(3, 12'h380, 2);
    drain();
    chk("t6_ptr_final", 32'(dut.ptr_q), 32'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
